// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide single-port RAM arbiter/sequencer for IF and MEM stages
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [31:0]           if_data,
    output logic                  if_done,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr,
    output logic [7:0]            ram_dout,
    input  logic [7:0]            ram_din
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_cnt, w_cnt_nxt;
    logic [2:0]            r_len;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_wdata;
    logic [31:0]           r_buf;
    logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
    logic                  r_ram_wr, w_ram_wr_nxt;
    logic [7:0]            r_ram_dout, w_ram_dout_nxt;
    logic                  r_if_done, w_if_done_nxt;
    logic                  r_mem_done, w_mem_done_nxt;

    logic                  w_grant_mem, w_grant_if;
    logic [2:0]            w_mem_len;
    logic [2:0]            w_cnt_inc;
    logic [1:0]            w_lane;
    logic                  w_reading;

    // A requester whose done pulse is up this cycle is not eligible, giving alternation
    assign w_grant_mem = (r_state == IDLE) && mem_req && !r_mem_done;
    assign w_grant_if  = (r_state == IDLE) && if_req && !r_if_done && !w_grant_mem;

    assign w_mem_len = (mem_size == 2'd0) ? 3'd1 : (mem_size == 2'd1) ? 3'd2 : 3'd4;
    assign w_cnt_inc = r_cnt + 3'd1;
    assign w_lane    = r_cnt[1:0] - 2'd1;
    assign w_reading = (r_state == IF_RD) || (r_state == MEM_RD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_ram_addr <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= '0;
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_wr   <= w_ram_wr_nxt;
            r_ram_dout <= w_ram_dout_nxt;
            r_if_done  <= w_if_done_nxt;
            r_mem_done <= w_mem_done_nxt;
            if (w_grant_mem) begin
                r_base  <= mem_addr;
                r_wdata <= mem_wdata;
                r_len   <= w_mem_len;
                r_buf   <= '0;
            end else if (w_grant_if) begin
                r_base <= if_addr;
                r_len  <= 3'd4;
                r_buf  <= '0;
            end else if (w_reading && r_cnt != 3'd0) begin
                // RAM returns the byte addressed one cycle earlier
                r_buf[{w_lane, 3'b000} +: 8] <= ram_din;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_grant_mem)     w_state_nxt = mem_we ? MEM_WR : MEM_RD;
                else if (w_grant_if) w_state_nxt = IF_RD;
            end
            IF_RD, MEM_RD: begin
                if (r_cnt == r_len) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            MEM_WR: begin
                if (w_cnt_inc == r_len) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_ram_addr_nxt = '0;
        w_ram_wr_nxt   = 1'b0;
        w_ram_dout_nxt = '0;
        w_if_done_nxt  = 1'b0;
        w_mem_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_mem) begin
                    w_ram_addr_nxt = mem_addr;
                    w_ram_wr_nxt   = mem_we;
                    w_ram_dout_nxt = mem_we ? mem_wdata[7:0] : 8'd0;
                end else if (w_grant_if) begin
                    w_ram_addr_nxt = if_addr;
                end
            end
            IF_RD, MEM_RD: begin
                if (w_cnt_inc < r_len)
                    w_ram_addr_nxt = r_base + ADDR_WIDTH'(w_cnt_inc);
                if (r_cnt == r_len) begin
                    w_if_done_nxt  = (r_state == IF_RD);
                    w_mem_done_nxt = (r_state == MEM_RD);
                end
            end
            MEM_WR: begin
                if (w_cnt_inc < r_len) begin
                    w_ram_addr_nxt = r_base + ADDR_WIDTH'(w_cnt_inc);
                    w_ram_wr_nxt   = 1'b1;
                    w_ram_dout_nxt = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
                end else begin
                    w_mem_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ram_addr  = r_ram_addr;
    assign ram_wr    = r_ram_wr;
    assign ram_dout  = r_ram_dout;
    assign if_done   = r_if_done;
    assign mem_done  = r_mem_done;
    assign if_data   = r_if_done  ? r_buf : 32'd0;
    assign mem_rdata = r_mem_done ? r_buf : 32'd0;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory arbiter/sequencer between the instruction-fetch stage (IF) and the MEM stage.
- Shares one byte-wide, 1-cycle-latency RAM port between the two requesters.
- Splits 1/2/4-byte accesses into byte transfers and assembles read data little-endian.
- Returns a one-cycle done pulse per transaction. The pipeline stall controller uses outstanding requests to hold the IF and MEM stages.

Parameters:
- ADDR_WIDTH, 32, width of all address ports; byte address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  IF requests a 4-byte instruction read; held high until if_done
- if_addr  in  ADDR_WIDTH  IF fetch byte address; stable while if_req high
- if_data  out  32  fetched instruction; valid only in the if_done cycle
- if_done  out  1  one-cycle pulse, IF transaction complete
- mem_req  in  1  MEM requests a load/store; held high until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- mem_addr  in  ADDR_WIDTH  MEM byte address
- mem_wdata  in  32  store data; byte k = bits [8k+7:8k]
- mem_rdata  out  32  load data, unused upper bytes zero; valid only in the mem_done cycle
- mem_done  out  1  one-cycle pulse, MEM transaction complete
- ram_addr  out  ADDR_WIDTH  RAM byte address (registered)
- ram_wr  out  1  RAM write enable (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_din  in  8  RAM read byte; returns data for the ram_addr of the previous cycle

Behaviour:
- State machine states: IDLE, IF_RD, MEM_RD, MEM_WR.
- Internal registers:
  - 3-bit byte counter cnt.
  - Length n: IF always 4; MEM byte = 1, half = 2, word or size 3 = 4.
  - Latched base address, write data and request type.
- Reset, or any cycle in IDLE with no grant:
  - ram_addr = 0, ram_wr = 0, ram_dout = 0.
  - if_done = 0, mem_done = 0.
  - if_data = 0, mem_rdata = 0.
  - State = IDLE, cnt = 0.
- Arbitration happens only in IDLE.
  - A requester whose done is high in the current cycle is ignored, so a held request cannot re-issue.
  - MEM has priority over IF when both are eligible.
  - There is no preemption: a granted transaction runs to completion.
  - Inputs are latched at grant; later changes are ignored.
- Read timing (IF_RD, MEM_RD), grant in cycle T:
  - ram_addr = base+k, ram_wr = 0 in cycle T+1+k, for k = 0..n-1.
  - ram_din byte k is sampled at the end of cycle T+2+k into byte lane k.
  - Done is high in cycle T+n+2, with if_data / mem_rdata holding the assembled value.
  - Word read: done at T+6. Byte read: done at T+3.
  - After the last address is issued, ram_addr returns to 0.
- Write timing (MEM_WR), grant in cycle T:
  - ram_addr = base+k, ram_wr = 1, ram_dout = mem_wdata byte k in cycle T+1+k.
  - mem_done is high in cycle T+n+1, with ram_wr = 0.
  - Word store: done at T+5. Byte store: done at T+2.
- The state returns to IDLE in the done cycle, so the next grant can occur in that same cycle.
  - That grant can only go to the other requester, per the ignore rule.
  - Result: strict alternation when both request continuously; IF is never starved.
- Done pulses last exactly 1 cycle. if_done and mem_done are never high simultaneously.
- Data outputs return to 0 the cycle after done.
- No alignment check. Misaligned accesses transfer bytes base..base+n-1 with address wrap-around.
- Reset mid-transaction:
  - Takes effect at the next edge: IDLE, all outputs zeroed, no done pulse.
  - A partially written store is left as written.

Test Plan:
- IF-only word fetch: if_addr = 0x100, RAM[0x100..0x103] = 13,00,A0,00 (hex). Required: ram_addr 0x100..0x103 in T+1..T+4, ram_wr = 0; if_done at T+6 with if_data = 0x00A00013.
- MEM byte store: mem_we = 1, mem_size = 0, mem_addr = 0x2000, mem_wdata = 0xDEADBEEF. Required: cycle T+1 ram_addr = 0x2000, ram_wr = 1, ram_dout = 0xEF; mem_done at T+2 with ram_wr = 0.
- Half load, zero-fill: mem_size = 1, addr 0x40, RAM = FF,80. Required: mem_done at T+4, mem_rdata = 0x000080FF.
- Simultaneous requests: if_req and mem_req (word load) both rise at T. Required: MEM is granted and mem_done at T+6; IF is granted at T+6 and if_done at T+12; no done cycles overlap.
- Held request after done: keep if_req high one cycle past if_done with mem_req low. Required: no re-grant in the done cycle; a new fetch is granted the following cycle.
- Reset mid-store: word store granted at T, rst high in cycle T+2. Required: at T+3 ram_wr = 0, ram_addr = 0, state IDLE; mem_done never asserted.
